// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM encoding and constants for the ALU op sequencer.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_GCD = 3'd4;
    localparam logic [2:0] OP_POW = 3'd5;

    // Replicated to the datapath width, so any WIDTH gets all ones.
    localparam logic [31:0] DIV0_RESULT = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_e;

endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: iteration registers and per-cycle step logic for div, gcd and pow.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);

    // x: dividend/quotient, gcd u, base; y: divisor, gcd v, exponent; z: remainder, accumulator
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   trial;
    logic             last;

    assign last = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        op_d   = op_q;
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        cnt_d  = cnt_q;
        done   = 1'b0;
        result = '0;
        err    = 1'b0;
        trial  = {z_q, x_q[WIDTH-1]};
        if (start) begin
            op_d  = op;
            x_d   = a;
            y_d   = b;
            z_d   = (op == OP_POW) ? WIDTH'(1) : '0;
            cnt_d = '0;
        end else if (step) begin
            case (op_q)
                OP_DIV: begin
                    if (y_q == '0) begin
                        done   = 1'b1;
                        err    = 1'b1;
                        result = {WIDTH{DIV0_RESULT[0]}};
                    end else begin
                        z_d    = (trial >= {1'b0, y_q}) ? WIDTH'(trial - {1'b0, y_q}) : trial[WIDTH-1:0];
                        x_d    = {x_q[WIDTH-2:0], trial >= {1'b0, y_q}};
                        cnt_d  = cnt_q + CW'(1);
                        done   = last;
                        result = x_d;
                    end
                end
                OP_GCD: begin
                    // Counter doubles as k, the shared power of two.
                    if (x_q == '0 || y_q == '0) begin
                        done   = 1'b1;
                        result = (x_q | y_q) << cnt_q;
                    end else if (!x_q[0] && !y_q[0]) begin
                        x_d   = x_q >> 1;
                        y_d   = y_q >> 1;
                        cnt_d = cnt_q + CW'(1);
                    end else if (!x_q[0]) begin
                        x_d = x_q >> 1;
                    end else if (!y_q[0]) begin
                        y_d = y_q >> 1;
                    end else if (x_q >= y_q) begin
                        x_d = (x_q - y_q) >> 1;
                    end else begin
                        y_d = (y_q - x_q) >> 1;
                    end
                end
                OP_POW: begin
                    z_d    = y_q[0] ? z_q * x_q : z_q;
                    x_d    = x_q * x_q;
                    y_d    = y_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    done   = last;
                    result = z_d;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            cnt_q <= '0;
        end else begin
            op_q  <= op_d;
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: request/response FSM around the shared ALU op set; iterative ops run in alu_iter_core.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_err,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [1:0]       rst_sync_q;
    logic             srst_n;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       sel_q, sel_d;
    logic             err_q, err_d;
    logic             accept, is_iter;
    logic             core_done, core_err;
    logic [WIDTH-1:0] core_res, simple_res;

    // Reset asserts asynchronously but releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign srst_n = rst_sync_q[1];

    assign in_ready   = state_q == ST_IDLE;
    assign out_valid  = state_q == ST_DONE;
    assign busy       = state_q != ST_IDLE;
    assign out_res    = res_q;
    assign out_err    = err_q;
    assign accept     = in_ready && in_valid;
    assign is_iter    = sel_q inside {OP_DIV, OP_GCD, OP_POW};
    assign simple_res = (sel_q == OP_SUB) ? b_q - a_q :
                        (sel_q == OP_MUL) ? a_q * b_q : a_q + b_q;

    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (srst_n),
        .start  (accept),
        .step   (state_q == ST_EXEC),
        .op     (in_sel),
        .a      (in_a),
        .b      (in_b),
        .done   (core_done),
        .result (core_res),
        .err    (core_err)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sel_d   = in_sel;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!is_iter || core_done) begin
                    res_d   = is_iter ? core_res : simple_res;
                    err_d   = is_iter && core_err;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

endmodule
